quadc_pattern_tx: RTL



---
 rtl/quadc_pkg.sv | 42 ++++
 rtl/quadc_prbs8_lane.sv | 35 +++
 rtl/quadc_pattern_tx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/quadc_pkg.sv
// Shared definitions for the quad-ADC capture and pattern-transmit paths.
// Word layout {adc0, adc1, adc2, adc3} with adc0 in the most significant byte.
package quadc_pkg;

   localparam int unsigned QUADC_LANES  = 4;
   localparam int unsigned QUADC_LANE_W = 8;

   typedef enum logic [1:0] {
      QUADC_MODE_CONST = 2'd0,
      QUADC_MODE_RAMP  = 2'd1,
      QUADC_MODE_PRBS  = 2'd2,
      QUADC_MODE_USER  = 2'd3
   } quadc_mode_e;

   typedef enum logic [1:0] {
      StIdle,
      StArm,
      StRun
   } quadc_state_e;

   typedef struct packed {
      logic [7:0] adc0;
      logic [7:0] adc1;
      logic [7:0] adc2;
      logic [7:0] adc3;
   } quadc_word_t;

   // Lane seeds packed in word order: lane0 = 8'h01 ... lane3 = 8'h08.
   localparam logic [31:0] QUADC_PRBS_SEEDS = 32'h0102_0408;
   localparam logic [7:0]  QUADC_PRBS_TAPS  = 8'hB8;

   // Bit position of the least significant bit of lane k within a word.
   function automatic int unsigned quadc_lane_lsb(input int unsigned k);
      return (QUADC_LANES - 1 - k) * QUADC_LANE_W;
   endfunction

   // Fibonacci x^8+x^6+x^5+x^4+1: shift left, feedback into bit 0.
   function automatic logic [7:0] quadc_prbs8_next(input logic [7:0] s);
      return {s[6:0], ^(s & QUADC_PRBS_TAPS)};
   endfunction

endpackage

// File: rtl/quadc_prbs8_lane.sv
// One PRBS8 lane generator: loads its seed on request and steps on advance.
module quadc_prbs8_lane
   import quadc_pkg::*;
#(
   parameter logic [7:0] SEED = 8'h01
) (
   input  logic       user_clk,
   input  logic       reset,
   input  logic       load_i,
   input  logic       advance_i,
   output logic [7:0] state_o
);

   logic [7:0] state_d, state_q;

   always_comb begin
      state_d = state_q;
      if (load_i) begin
         state_d = SEED;
      end else if (advance_i) begin
         state_d = quadc_prbs8_next(state_q);
      end
   end

   always_ff @(posedge user_clk) begin
      if (reset) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/quadc_pattern_tx.sv
// Quad-ADC pattern transmitter: constant, ramp, PRBS8 or user-stream samples
// on four 8-bit lanes plus a sync strobe, with one output register stage.
module quadc_pattern_tx
   import quadc_pkg::*;
#(
   parameter int unsigned SYNC_W    = 16,
   parameter int unsigned RAMP_STEP = 64
) (
   input  logic              user_clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [1:0]        mode,
   input  logic [SYNC_W-1:0] sync_period,
   input  logic [31:0]       const_value,
   input  logic [31:0]       user_data,
   input  logic              user_valid,
   output logic              user_ready,
   output logic [7:0]        adc0_data_out,
   output logic [7:0]        adc1_data_out,
   output logic [7:0]        adc2_data_out,
   output logic [7:0]        adc3_data_out,
   output logic              sync_out,
   output logic              active,
   output logic              underflow
);

   quadc_state_e      state_d, state_q;
   quadc_mode_e       mode_d, mode_q;
   logic [SYNC_W-1:0] sync_period_d, sync_period_q;
   logic [SYNC_W-1:0] sync_cnt_d, sync_cnt_q;
   logic [7:0]        count_d, count_q;
   quadc_word_t       data_d, data_q;
   logic              sync_d, sync_q;
   logic              active_d, active_q;
   logic              underflow_d, underflow_q;

   logic              lfsr_load, lfsr_adv;
   logic [31:0]       prbs_word;
   logic [31:0]       ramp_word;

   for (genvar k = 0; k < QUADC_LANES; k++) begin : g_lane
      localparam int unsigned LaneLsb = (QUADC_LANES - 1 - k) * QUADC_LANE_W;
      quadc_prbs8_lane #(
         .SEED(QUADC_PRBS_SEEDS[LaneLsb +: QUADC_LANE_W])
      ) u_prbs (
         .user_clk (user_clk),
         .reset    (reset),
         .load_i   (lfsr_load),
         .advance_i(lfsr_adv),
         .state_o  (prbs_word[LaneLsb +: QUADC_LANE_W])
      );
   end

   always_comb begin
      ramp_word = '0;
      for (int unsigned k = 0; k < QUADC_LANES; k++) begin
         ramp_word[quadc_lane_lsb(k) +: QUADC_LANE_W] = count_q + 8'((k * RAMP_STEP) % 256);
      end
   end

   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      sync_period_d = sync_period_q;
      sync_cnt_d    = sync_cnt_q;
      count_d       = count_q;
      underflow_d   = underflow_q;
      data_d        = '0;
      sync_d        = 1'b0;
      active_d      = 1'b0;
      lfsr_load     = 1'b0;
      lfsr_adv      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (enable) state_d = StArm;
         end
         StArm: begin
            mode_d        = quadc_mode_e'(mode);
            sync_period_d = sync_period;
            sync_cnt_d    = '0;
            count_d       = '0;
            underflow_d   = 1'b0;
            lfsr_load     = 1'b1;
            state_d       = StRun;
         end
         StRun: begin
            active_d   = 1'b1;
            // A zero period leaves the counter free-running but never strobes.
            sync_d     = (sync_period_q != '0) && (sync_cnt_q == '0);
            sync_cnt_d = (sync_cnt_q == sync_period_q - SYNC_W'(1)) ? '0
                                                                     : sync_cnt_q + SYNC_W'(1);
            unique case (mode_q)
               QUADC_MODE_CONST: data_d = const_value;
               QUADC_MODE_RAMP: begin
                  data_d  = ramp_word;
                  count_d = count_q + 8'd1;
               end
               QUADC_MODE_PRBS: begin
                  data_d   = prbs_word;
                  lfsr_adv = 1'b1;
               end
               QUADC_MODE_USER: begin
                  if (user_valid) begin
                     data_d = user_data;
                  end else begin
                     underflow_d = 1'b1;
                  end
               end
            endcase
            if (!enable) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge user_clk) begin
      if (reset) begin
         state_q       <= StIdle;
         mode_q        <= QUADC_MODE_CONST;
         sync_period_q <= '0;
         sync_cnt_q    <= '0;
         count_q       <= '0;
         data_q        <= '0;
         sync_q        <= 1'b0;
         active_q      <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         sync_period_q <= sync_period_d;
         sync_cnt_q    <= sync_cnt_d;
         count_q       <= count_d;
         data_q        <= data_d;
         sync_q        <= sync_d;
         active_q      <= active_d;
         underflow_q   <= underflow_d;
      end
   end

   assign user_ready    = (state_q == StRun);
   assign adc0_data_out = data_q.adc0;
   assign adc1_data_out = data_q.adc1;
   assign adc2_data_out = data_q.adc2;
   assign adc3_data_out = data_q.adc3;
   assign sync_out      = sync_q;
   assign active        = active_q;
   assign underflow     = underflow_q;

endmodule
